dual_issue_ctrl: RTL
====================

// Module: dual_issue_ctrl
// PURPOSE
//  Consumes the two head entries of the frontend instruction FIFO (inst_t[1:0] + valid) and decides per cycle how many issue (0/1/2).
//  Tracks in-flight long-latency writes in a register scoreboard and checks intra-pair hazards.
//  Registers issued instructions into two in-order execution slots. Drives issue_num / backend_stall back to the frontend FIFO read port.
// PARAMETERS
//  NUM_WB   2   number of writeback ports that clear scoreboard bits
//  NUM_REG  32  architectural GPR count (scoreboard width); r0 never tracked
// PORTS
//  clk              in   1        clock; all state updates on posedge
//  rst              in   1        reset, synchronous, active-high
//  flush_i          in   1        pipeline flush (same signal as BPU feedback flush)
//  inst_i           in   2xinst_t FIFO head entries, [0] is oldest
//  inst_valid_i     in   2        per-entry valid from FIFO
//  issue_num_o      out  2        entries consumed this cycle (0,1,2); comb
//  backend_stall_o  out  1        1 = FIFO must not advance; comb
//  slot_inst_o      out  2xinst_t registered issued instructions, [0] older
//  slot_valid_o     out  2        registered slot valids
//  slot_ready_i     in   1        execute stage accepts slots this cycle
//  wb_valid_i       in   NUM_WB   long-latency writeback valid
//  wb_reg_i         in   NUM_WBx5 writeback destination register
// BEHAVIOUR
//  Reset (rst=1 at posedge): slot_valid_o=0, slot_inst_o=0, scoreboard=0, perf counters=0; issue_num_o=0 while rst=1.
//  Hold: slot_ready_i=0 and any slot_valid_o=1 -> slots hold; issue_num_o=0; backend_stall_o=1.
//  Slot advance: otherwise slots load the new issue group next cycle; 1-cycle latency FIFO head -> slot_*_o.
//  backend_stall_o = hold | flush_i | (issue_num_o==0).
//  Issue class per inst comes from the package: mem, long (load/mul/div), single (csr/priv/tlb/barrier/ertn/syscall/break), branch.
//  Slot0 issues iff all hold:
//   - inst_valid_i[0], no hold, no flush_i;
//   - every nonzero r_reg clear in scoreboard after this cycle's wb clears (wb bypass);
//   - nonzero w_reg clear in scoreboard (WAW).
//  Slot1 issues iff all hold:
//   - slot0 issues, inst_valid_i[1], neither inst single;
//   - not both mem; inst0 not branch (branch must be last of pair);
//   - inst1 r_reg/w_reg nonzero and != inst0.w_reg;
//   - inst1 passes the same scoreboard checks as slot0.
//  issue_num_o = slot0 + slot1; a partially issued pair leaves inst1 at the FIFO head next cycle.
//  Scoreboard: set bit w_reg on issue of a long inst with w_reg!=0; clear on wb_valid_i[k] for wb_reg_i[k].
//   Same-cycle set and clear of the same reg -> set wins. Bit 0 is hardwired 0.
//  flush_i: issue_num_o=0 that cycle; next cycle slot_valid_o=0 and scoreboard=0. Flush overrides hold.
//  Reset or flush mid-hold drops held slots; no partial state survives.
//  slot_inst_o[1] is valid only if slot_valid_o[0]; slot_valid_o==2'b10 never occurs.
// CONFIGURATION
//  ISSUE_PERF_CNT_EN defined:
//   - adds outputs perf_dual_o, perf_single_o, perf_zero_o (32b each), counting cycles with issue_num 2/1/0 while not in reset;
//   - counters wrap at 2^32 and are not cleared by flush.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package (pipeline types): issue_class_t struct, function get_issue_class(decode_info_t), ISSUE_NUM_W constant.
//  Sub-module issue_scoreboard holds the NUM_REG-bit vector.
//   - Inputs: set_valid/set_reg x2, clr_valid/clr_reg xNUM_WB, flush.
//   - Output: busy vector with wb bypass applied.
//  Top holds hazard logic, slot registers and the optional counters.
// TESTING
//  Two independent ALU ops (r4<-r1,r2; r5<-r3,r6), slot_ready=1 -> issue_num=2, both slots valid next cycle.
//  inst0 writes r7, inst1 reads r7 -> issue_num=1; next cycle inst1 issues as slot0.
//  Load to r9 issued, then add reading r9 -> issue_num=0 until wb_valid=1, wb_reg=9; issues that same cycle (bypass).
//  slot_ready_i=0 for 3 cycles with valid slots -> slots stable, issue_num=0, backend_stall=1 throughout.
//  flush_i during hold with r9 pending -> next cycle slot_valid=0, scoreboard bit 9 =0, add reading r9 issues immediately.
//  Two loads, or csrwr paired with add -> issue_num=1 each cycle; ISSUE_PERF_CNT_EN: perf_single increments per cycle.

Source files
------------

// File: rtl/dual_issue_ctrl_pkg.sv
// Pipeline types shared by the dual-issue controller: instruction format,
// issue classes and the decode-to-class mapping.
package dual_issue_ctrl_pkg;

  localparam int unsigned ISSUE_NUM_W = 2;
  localparam int unsigned REG_W       = 5;

  typedef enum logic [3:0] {
    OP_ALU,
    OP_BRANCH,
    OP_LOAD,
    OP_STORE,
    OP_MUL,
    OP_DIV,
    OP_CSR,
    OP_PRIV,
    OP_TLB,
    OP_BARRIER,
    OP_ERTN,
    OP_SYSCALL,
    OP_BREAK
  } op_t;

  typedef struct packed {
    op_t op;
  } decode_info_t;

  typedef struct packed {
    logic [31:0]             pc;
    decode_info_t            info;
    logic [1:0][REG_W-1:0]   r_reg;
    logic [REG_W-1:0]        w_reg;
  } inst_t;

  typedef struct packed {
    logic mem;
    logic long_lat;
    logic single;
    logic branch;
  } issue_class_t;

  function automatic issue_class_t get_issue_class(decode_info_t d);
    issue_class_t c;
    c = '0;
    case (d.op)
      OP_LOAD:   begin c.mem = 1'b1; c.long_lat = 1'b1; end
      OP_STORE:  c.mem = 1'b1;
      OP_MUL,
      OP_DIV:    c.long_lat = 1'b1;
      OP_BRANCH: c.branch = 1'b1;
      OP_CSR, OP_PRIV, OP_TLB, OP_BARRIER,
      OP_ERTN, OP_SYSCALL, OP_BREAK: c.single = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dual_issue_ctrl_scoreboard.sv
// Register scoreboard for in-flight long-latency writes; busy output already
// has this cycle's writeback clears applied.
module issue_scoreboard
  import dual_issue_ctrl_pkg::*;
#(
  parameter int unsigned NUM_WB  = 2,
  parameter int unsigned NUM_REG = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [1:0]                    set_valid,
  input  logic [1:0][REG_W-1:0]         set_reg,
  input  logic [NUM_WB-1:0]             clr_valid,
  input  logic [NUM_WB-1:0][REG_W-1:0]  clr_reg,
  output logic [NUM_REG-1:0]            busy
);

  logic [NUM_REG-1:0] sb;
  logic [NUM_REG-1:0] clr_mask;
  logic [NUM_REG-1:0] set_mask;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    for (int unsigned k = 0; k < NUM_WB; k++)
      if (clr_valid[k]) clr_mask[clr_reg[k]] = 1'b1;
    for (int unsigned k = 0; k < 2; k++)
      if (set_valid[k]) set_mask[set_reg[k]] = 1'b1;
    busy = sb & ~clr_mask;
  end

  // Set is OR-ed after the clear so a same-cycle set wins; r0 is never tracked.
  always_ff @(posedge clk) begin
    if (rst || flush) sb <= '0;
    else              sb <= (busy | set_mask) & ~NUM_REG'(1);
  end

endmodule

// File: rtl/dual_issue_ctrl.sv
// Dual-issue controller: picks 0/1/2 FIFO head entries per cycle and registers
// them into two in-order slots. Optional perf counters via ISSUE_PERF_CNT_EN.
module dual_issue_ctrl
  import dual_issue_ctrl_pkg::*;
#(
  parameter int unsigned NUM_WB  = 2,
  parameter int unsigned NUM_REG = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  inst_t [1:0]                   inst_i,
  input  logic [1:0]                    inst_valid_i,
  output logic [ISSUE_NUM_W-1:0]        issue_num_o,
  output logic                          backend_stall_o,
  output inst_t [1:0]                   slot_inst_o,
  output logic [1:0]                    slot_valid_o,
  input  logic                          slot_ready_i,
  input  logic [NUM_WB-1:0]             wb_valid_i,
  input  logic [NUM_WB-1:0][REG_W-1:0]  wb_reg_i
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_dual_o,
  output logic [31:0]                   perf_single_o,
  output logic [31:0]                   perf_zero_o
`endif
);

  issue_class_t         cls0, cls1;
  logic [NUM_REG-1:0]   busy;
  logic                 hold;
  logic                 sb_ok0, sb_ok1;
  logic                 pair_dep, pair_ok;
  logic                 issue0, issue1;
  logic [1:0]           set_valid;
  logic [1:0][REG_W-1:0] set_reg;
  inst_t [1:0]          slot_next;

  function automatic logic regs_free(inst_t i, logic [NUM_REG-1:0] b);
    logic ok;
    ok = 1'b1;
    for (int unsigned k = 0; k < 2; k++)
      if (i.r_reg[k] != '0 && b[i.r_reg[k]]) ok = 1'b0;
    if (i.w_reg != '0 && b[i.w_reg]) ok = 1'b0;
    return ok;
  endfunction

  issue_scoreboard #(
    .NUM_WB  (NUM_WB),
    .NUM_REG (NUM_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_i),
    .set_valid (set_valid),
    .set_reg   (set_reg),
    .clr_valid (wb_valid_i),
    .clr_reg   (wb_reg_i),
    .busy      (busy)
  );

  always_comb begin
    cls0   = get_issue_class(inst_i[0].info);
    cls1   = get_issue_class(inst_i[1].info);
    hold   = (|slot_valid_o) && !slot_ready_i;
    sb_ok0 = regs_free(inst_i[0], busy);
    sb_ok1 = regs_free(inst_i[1], busy);

    // Any nonzero register of inst1 matching inst0's destination is a hazard.
    pair_dep = (inst_i[1].r_reg[0] != '0 && inst_i[1].r_reg[0] == inst_i[0].w_reg) ||
               (inst_i[1].r_reg[1] != '0 && inst_i[1].r_reg[1] == inst_i[0].w_reg) ||
               (inst_i[1].w_reg    != '0 && inst_i[1].w_reg    == inst_i[0].w_reg);

    pair_ok = inst_valid_i[1] && !cls0.single && !cls1.single &&
              !(cls0.mem && cls1.mem) && !cls0.branch && !pair_dep && sb_ok1;

    issue0 = inst_valid_i[0] && !rst && !hold && !flush_i && sb_ok0;
    issue1 = issue0 && pair_ok;

    issue_num_o     = ISSUE_NUM_W'(issue0) + ISSUE_NUM_W'(issue1);
    backend_stall_o = hold || flush_i || (issue_num_o == '0);

    set_valid[0] = issue0 && cls0.long_lat && (inst_i[0].w_reg != '0);
    set_valid[1] = issue1 && cls1.long_lat && (inst_i[1].w_reg != '0);
    set_reg[0]   = inst_i[0].w_reg;
    set_reg[1]   = inst_i[1].w_reg;

    slot_next = '0;
    if (issue0) slot_next[0] = inst_i[0];
    if (issue1) slot_next[1] = inst_i[1];
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      slot_valid_o <= '0;
      slot_inst_o  <= '0;
    end else if (!hold) begin
      slot_valid_o <= {issue1, issue0};
      slot_inst_o  <= slot_next;
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_dual_o   <= '0;
      perf_single_o <= '0;
      perf_zero_o   <= '0;
    end else begin
      case (issue_num_o)
        2'd2:    perf_dual_o   <= perf_dual_o + 32'd1;
        2'd1:    perf_single_o <= perf_single_o + 32'd1;
        default: perf_zero_o   <= perf_zero_o + 32'd1;
      endcase
    end
  end
`endif

endmodule
